fetch_unit: RTL and testbench

- Instruction-fetch front end that produces the instruction stream the decode stage consumes.
- Holds the PC and issues reads to instruction memory, which has variable latency and allows one outstanding request.
- Buffers returned words with their PC+2 in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects from execute, and halt.

---
 rtl/fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem reads, a small
// instruction FIFO towards decode, redirect/halt handling.
module fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP      = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_data,
  input  logic        imem_done,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [15:0] instruction,
  output logic [15:0] pc_plus2,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP,
    S_HALTED
  } state_t;

  state_t        state;
  logic [15:0]   pc;
  logic [15:0]   addr;
  logic          rd;
  logic          halt_pend;
  logic          err_q;

  logic [15:0]   buf_instr [DEPTH];
  logic [15:0]   buf_pc2   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          pop;
  logic          push;
  logic          take_halt;
  logic          take_redir;
  logic          flush;
  logic [CW-1:0] occ_next;
  logic          slot_ok;
  logic [15:0]   pc_inc;
  logic [15:0]   redir_pc;

  // A redirect arriving while a halt is draining its request is ignored,
  // same as a redirect once halted.
  always_comb begin
    pop        = (count != '0) && instr_ready;
    take_halt  = halt && (state != S_HALTED);
    take_redir = redirect && !halt && (state != S_HALTED) && !halt_pend;
    flush      = take_halt || take_redir;
    push       = (state == S_WAIT) && imem_done && !flush;
    occ_next   = count + CW'(push) - CW'(pop);
    slot_ok    = occ_next < CW'(DEPTH);
    pc_inc     = pc + 16'd2;
    redir_pc   = {redirect_pc[15:1], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      addr      <= RESET_PC;
      rd        <= 1'b0;
      halt_pend <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= (imem_done && !rd) || (take_redir && redirect_pc[0]);
      case (state)
        S_IDLE: begin
          if (take_halt) begin
            state <= S_HALTED;
          end else if (take_redir) begin
            pc   <= redir_pc;
            addr <= redir_pc;
          end else if (slot_ok) begin
            state <= S_WAIT;
            rd    <= 1'b1;
            addr  <= pc;
          end
        end
        S_WAIT: begin
          if (take_halt) begin
            if (imem_done) begin
              state <= S_HALTED;
              rd    <= 1'b0;
            end else begin
              state     <= S_DROP;
              halt_pend <= 1'b1;
            end
          end else if (take_redir) begin
            pc <= redir_pc;
            if (imem_done) begin
              state <= S_IDLE;
              rd    <= 1'b0;
              addr  <= redir_pc;
            end else begin
              state <= S_DROP;
            end
          end else if (imem_done) begin
            pc   <= pc_inc;
            addr <= pc_inc;
            if (slot_ok) begin
              state <= S_WAIT;
            end else begin
              state <= S_IDLE;
              rd    <= 1'b0;
            end
          end
        end
        S_DROP: begin
          // addr keeps the abandoned request's address until memory answers
          if (take_halt) halt_pend <= 1'b1;
          if (take_redir) pc <= redir_pc;
          if (imem_done) begin
            rd    <= 1'b0;
            state <= (halt_pend || take_halt) ? S_HALTED : S_IDLE;
            addr  <= take_redir ? redir_pc : pc;
          end
        end
        default: begin
          state <= S_HALTED;
          rd    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= occ_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_data;
      buf_pc2[wr_ptr]   <= pc_inc;
    end
  end

  always_comb begin
    imem_rd     = rd;
    imem_addr   = addr;
    err         = err_q;
    instr_valid = (count != '0);
    instruction = instr_valid ? buf_instr[rd_ptr] : NOP;
    pc_plus2    = instr_valid ? buf_pc2[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against a program-order
// stream model and a variable-latency memory responder.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] imem_data;
  logic        imem_done;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        instr_ready;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [15:0] pc_plus2;
  logic        err;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  int unsigned lat      = 0;
  logic        rand_lat = 1'b0;
  logic        force_done = 1'b0;
  int unsigned mcnt     = 0;

  logic        sb_on   = 1'b0;
  logic [15:0] sb_exp  = 16'h0000;
  int unsigned sb_pops = 0;
  logic        err_exp = 1'b0;

  fetch_unit #(
    .DEPTH   (2),
    .RESET_PC(16'h0000),
    .NOP     (16'h0800)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_data  (imem_data),
    .imem_done  (imem_done),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .instr_ready(instr_ready),
    .instr_valid(instr_valid),
    .instruction(instruction),
    .pc_plus2   (pc_plus2),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Memory: word at address a is 16'hA000 + a; done after 'lat' extra cycles.
  initial begin
    imem_done = 1'b0;
    imem_data = 16'h0000;
  end
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mcnt      = 0;
      imem_done = 1'b0;
    end else if (imem_rd) begin
      if (mcnt >= lat) begin
        imem_done = 1'b1;
        imem_data = 16'hA000 + imem_addr;
        mcnt      = 0;
        if (rand_lat) lat = $urandom_range(0, 3);
      end else begin
        imem_done = 1'b0;
        mcnt      = mcnt + 1;
      end
    end else begin
      imem_done = force_done;
      imem_data = 16'h1234;
      mcnt      = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, update the stream model, advance to edge+2.
  task automatic cycle(input logic rdy, input logic rdr, input logic [15:0] rpc, input logic hlt);
    if (sb_on) chk("err_model", {31'b0, err}, {31'b0, err_exp});
    instr_ready = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
    halt        = hlt;
    if (sb_on) begin
      if (rdr) begin
        sb_exp = {rpc[15:1], 1'b0};
      end else if (instr_valid && rdy) begin
        chk("stream_instr", {16'b0, instruction}, {16'b0, 16'hA000 + sb_exp});
        chk("stream_pc2", {16'b0, pc_plus2}, {16'b0, sb_exp + 16'd2});
        sb_exp  = sb_exp + 16'd2;
        sb_pops = sb_pops + 1;
      end
    end
    err_exp = sb_on && rdr && rpc[0] && !hlt;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    force_done = 1'b0; rand_lat = 1'b0; sb_on = 1'b0; err_exp = 1'b0;
    sb_exp = 16'h0000; sb_pops = 0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("rst_rd",    {31'b0, imem_rd}, 32'd0);
    chk("rst_addr",  {16'b0, imem_addr}, 32'h0000);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", {16'b0, instruction}, 32'h0800);
    chk("rst_pc2",   {16'b0, pc_plus2}, 32'h0000);
    chk("rst_err",   {31'b0, err}, 32'd0);
    rst = 1'b0;
  endtask

  int unsigned pops_before;
  logic        reached;

  initial begin
    // Zero-latency streaming
    do_reset();
    lat = 0; sb_on = 1'b1;
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t1_rd", {31'b0, imem_rd}, 32'd1);
    chk("t1_addr", {16'b0, imem_addr}, 32'h0000);
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
      chk("t1_instr", {16'b0, instruction}, 32'hA000 + 32'(2 * k));
      chk("t1_pc2", {16'b0, pc_plus2}, 32'(2 * k + 2));
    end

    // Fill with decode stalled, then drain
    do_reset();
    lat = 2; sb_on = 1'b1;
    for (int k = 0; k < 12; k++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t2_full_rd", {31'b0, imem_rd}, 32'd0);
    chk("t2_full_valid", {31'b0, instr_valid}, 32'd1);
    chk("t2_head", {16'b0, instruction}, 32'hA000);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t2_hold_rd", {31'b0, imem_rd}, 32'd0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t2_resume_rd", {31'b0, imem_rd}, 32'd1);
    chk("t2_second", {16'b0, instruction}, 32'hA002);
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t2_drained", {31'b0, sb_pops >= 5}, 32'd1);

    // Redirect while the request to 0x0004 is outstanding
    do_reset();
    lat = 2; sb_on = 1'b1;
    for (int k = 0; k < 20 && !(imem_rd && imem_addr == 16'h0004); k++)
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t3_req4", {31'b0, imem_rd && imem_addr == 16'h0004}, 32'd1);
    chk("t3_pending", {31'b0, imem_done}, 32'd0);
    cycle(1'b1, 1'b1, 16'h0040, 1'b0);
    chk("t3_drop_rd", {31'b0, imem_rd}, 32'd1);
    chk("t3_drop_addr", {16'b0, imem_addr}, 32'h0004);
    chk("t3_drop_valid", {31'b0, instr_valid}, 32'd0);
    for (int k = 0; k < 20 && !(imem_rd && imem_addr != 16'h0004); k++)
      cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t3_new_addr", {16'b0, imem_addr}, 32'h0040);
    pops_before = sb_pops;
    for (int k = 0; k < 10; k++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t3_presented", {31'b0, sb_pops > pops_before}, 32'd1);

    // Halt with two entries buffered
    do_reset();
    lat = 0;
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t4_buffered", {31'b0, instr_valid}, 32'd1);
    cycle(1'b0, 1'b0, 16'h0, 1'b1);
    chk("t4_valid", {31'b0, instr_valid}, 32'd0);
    chk("t4_instr", {16'b0, instruction}, 32'h0800);
    chk("t4_pc2", {16'b0, pc_plus2}, 32'h0000);
    cycle(1'b1, 1'b1, 16'h0100, 1'b0);
    for (int k = 0; k < 8; k++) begin
      chk("t4_halted_rd", {31'b0, imem_rd}, 32'd0);
      chk("t4_halted_valid", {31'b0, instr_valid}, 32'd0);
      cycle(1'b1, k[0], 16'h0200, 1'b0);
    end
    do_reset();
    lat = 0;
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t4_restart_rd", {31'b0, imem_rd}, 32'd1);
    chk("t4_restart_addr", {16'b0, imem_addr}, 32'h0000);

    // Halt while a request is outstanding
    do_reset();
    lat = 3;
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b1);
    chk("t4b_drain_rd", {31'b0, imem_rd}, 32'd1);
    chk("t4b_drain_addr", {16'b0, imem_addr}, 32'h0000);
    for (int k = 0; k < 10 && imem_rd; k++) cycle(1'b1, 1'b0, 16'h0, 1'b0);
    reached = !imem_rd;
    chk("t4b_done", {31'b0, reached}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b1, 16'h0080, 1'b0);
      chk("t4b_halted_rd", {31'b0, imem_rd}, 32'd0);
      chk("t4b_halted_valid", {31'b0, instr_valid}, 32'd0);
    end

    // PC wrap and misaligned redirect
    do_reset();
    lat = 0; sb_on = 1'b1;
    cycle(1'b1, 1'b1, 16'hFFFE, 1'b0);
    chk("t5_idle", {31'b0, imem_rd}, 32'd0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t5_addr_fffe", {16'b0, imem_addr}, 32'hFFFE);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t5_instr", {16'b0, instruction}, 32'h9FFE);
    chk("t5_pc2_wrap", {16'b0, pc_plus2}, 32'h0000);
    chk("t5_addr_wrap", {16'b0, imem_addr}, 32'h0000);
    cycle(1'b1, 1'b1, 16'h0033, 1'b0);
    chk("t5_err", {31'b0, err}, 32'd1);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t5_err_clear", {31'b0, err}, 32'd0);
    chk("t5_aligned", {16'b0, imem_addr}, 32'h0032);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 16'h0, 1'b0);

    // Spurious imem_done while idle
    do_reset();
    lat = 0;
    for (int k = 0; k < 4; k++) cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t6_idle", {31'b0, imem_rd}, 32'd0);
    force_done = 1'b1;
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    force_done = 1'b0;
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t6_err", {31'b0, err}, 32'd1);
    chk("t6_head", {16'b0, instruction}, 32'hA000);
    cycle(1'b0, 1'b0, 16'h0, 1'b0);
    chk("t6_err_clear", {31'b0, err}, 32'd0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0);
    chk("t6_second", {16'b0, instruction}, 32'hA002);

    // Randomized latency, back-pressure and redirects
    do_reset();
    rand_lat = 1'b1; lat = 1; sb_on = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      logic        r_rdy;
      logic        r_rdr;
      logic [15:0] r_pc;
      r_rdy = ($urandom_range(0, 3) != 0);
      r_rdr = ($urandom_range(0, 15) == 0);
      r_pc  = 16'($urandom);
      cycle(r_rdy, r_rdr, r_pc, 1'b0);
    end
    chk("rand_progress", {31'b0, sb_pops > 200}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
